// File: rtl/metronome_pkg.sv
// metronome_pkg: shared command, state and source encodings for the metronome command arbiter
// Contents: CMD_* adjust codes, state_t FSM encoding, SRC_* grant source encoding.
package metronome_pkg;

    localparam logic [1:0] CMD_PLUS_1  = 2'b00;
    localparam logic [1:0] CMD_PLUS_5  = 2'b01;
    localparam logic [1:0] CMD_MINUS_1 = 2'b10;
    localparam logic [1:0] CMD_MINUS_5 = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    localparam logic SRC_BTN  = 1'b0;
    localparam logic SRC_UART = 1'b1;

endpackage

// File: rtl/btn_repeat_gen.sv
// btn_repeat_gen: button edge detect, conflict check, hold/auto-repeat timing and single pending slot
// Ports: i_clk, i_reset (async, active high); i_btn = {minus_5, minus_1, plus_5, plus_1} levels;
//        i_clr_pending drops the slot when the arbiter grants it; o_pending/o_code = pending request.
module btn_repeat_gen
    import metronome_pkg::*;
#(
    parameter int HOLD_CYCLES   = 25_000_000,
    parameter int REPEAT_CYCLES = 5_000_000
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [3:0] i_btn,
    input  logic       i_clr_pending,
    output logic       o_pending,
    output logic [1:0] o_code
);
    localparam int CW = $clog2(HOLD_CYCLES > REPEAT_CYCLES ? HOLD_CYCLES : REPEAT_CYCLES) + 1;
    logic [3:0]    prev;
    logic [CW-1:0] cnt;
    logic          rep;
    logic          single, rise, held, fire;
    logic [1:0]    code;
    assign single = i_btn != 4'd0 && (i_btn & (i_btn - 4'd1)) == 4'd0;
    assign rise   = single && i_btn != prev;
    assign held   = single && i_btn == prev;
    // cnt is the number of cycles since the press (or since the last repeat)
    assign fire   = held && cnt == (rep ? CW'(REPEAT_CYCLES) : CW'(HOLD_CYCLES));
    // one-hot level to command code
    assign code   = {i_btn[3] | i_btn[2], i_btn[3] | i_btn[1]};
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            prev      <= '0;
            cnt       <= '0;
            rep       <= 1'b0;
            o_pending <= 1'b0;
            o_code    <= '0;
        end else begin
            prev <= i_btn;
            if (!single) begin
                cnt <= '0;
                rep <= 1'b0;
            end else if (rise) begin
                cnt <= CW'(1);
                rep <= 1'b0;
            end else if (fire) begin
                cnt <= CW'(1);
                rep <= 1'b1;
            end else if (cnt != '1) begin
                cnt <= cnt + 1'b1;
            end
            if (i_clr_pending) begin
                o_pending <= 1'b0;
            end else if ((rise || fire) && !o_pending) begin
                o_pending <= 1'b1;
                o_code    <= code;
            end
        end
    end
endmodule

// File: rtl/metronome_cmd_arbiter.sv
// metronome_cmd_arbiter: round-robin arbiter turning button/UART tempo commands into gapped single-cycle pulses
// Ports: i_clk, i_reset (async, active high); i_btn_* debounced levels; i_uart_cmd_valid/i_uart_cmd
//        with combinational o_uart_cmd_ready; o_plus_1/o_plus_5/o_minus_1/o_minus_5 pulses;
//        o_busy (ISSUE or GAP); o_last_src (0 button, 1 UART).
module metronome_cmd_arbiter
    import metronome_pkg::*;
#(
    parameter int GAP_CYCLES    = 16,
    parameter int HOLD_CYCLES   = 25_000_000,
    parameter int REPEAT_CYCLES = 5_000_000
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_btn_plus_1,
    input  logic       i_btn_plus_5,
    input  logic       i_btn_minus_1,
    input  logic       i_btn_minus_5,
    input  logic       i_uart_cmd_valid,
    input  logic [1:0] i_uart_cmd,
    output logic       o_uart_cmd_ready,
    output logic       o_plus_1,
    output logic       o_plus_5,
    output logic       o_minus_1,
    output logic       o_minus_5,
    output logic       o_busy,
    output logic       o_last_src
);
    localparam int GW = $clog2(GAP_CYCLES) + 1;
    state_t        state, state_n;
    logic          btn_pending, grant_uart, any_req, clr_btn;
    logic [1:0]    btn_code, code_q;
    logic          src_q;
    logic [GW-1:0] gap_cnt;
    btn_repeat_gen #(
        .HOLD_CYCLES  (HOLD_CYCLES),
        .REPEAT_CYCLES(REPEAT_CYCLES)
    ) u_btn (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_btn        ({i_btn_minus_5, i_btn_minus_1, i_btn_plus_5, i_btn_plus_1}),
        .i_clr_pending(clr_btn),
        .o_pending    (btn_pending),
        .o_code       (btn_code)
    );
    assign any_req    = btn_pending || i_uart_cmd_valid;
    // with both requesting, the source that did not win last time goes first
    assign grant_uart = i_uart_cmd_valid && (!btn_pending || o_last_src == SRC_BTN);
    assign clr_btn    = state == ST_IDLE && btn_pending && !grant_uart;
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) state <= ST_IDLE;
        else         state <= state_n;
    end
    always_comb begin
        state_n = state == ST_IDLE  ? (any_req ? ST_ISSUE : ST_IDLE) :
                  state == ST_ISSUE ? ST_GAP :
                  (gap_cnt == '0 ? ST_IDLE : ST_GAP);
    end
    always_comb begin
        o_uart_cmd_ready = state == ST_IDLE && grant_uart;
        o_busy           = state != ST_IDLE;
        o_plus_1         = state == ST_ISSUE && code_q == CMD_PLUS_1;
        o_plus_5         = state == ST_ISSUE && code_q == CMD_PLUS_5;
        o_minus_1        = state == ST_ISSUE && code_q == CMD_MINUS_1;
        o_minus_5        = state == ST_ISSUE && code_q == CMD_MINUS_5;
    end
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            code_q     <= '0;
            src_q      <= SRC_BTN;
            gap_cnt    <= '0;
            o_last_src <= SRC_BTN;
        end else if (state == ST_IDLE && any_req) begin
            code_q <= grant_uart ? i_uart_cmd : btn_code;
            src_q  <= grant_uart ? SRC_UART : SRC_BTN;
        end else if (state == ST_ISSUE) begin
            gap_cnt    <= GW'(GAP_CYCLES - 1);
            o_last_src <= src_q;
        end else if (state == ST_GAP && gap_cnt != '0) begin
            gap_cnt <= gap_cnt - 1'b1;
        end
    end
endmodule

// File: tb/tb_metronome_cmd_arbiter.sv
// tb_metronome_cmd_arbiter: vector table, corner sequences and randomized reference-model check
module tb_metronome_cmd_arbiter;
    localparam int GAP = 16, HOLD = 100, REP = 20;
    logic       clk = 1'b0, rst = 1'b1;
    logic [3:0] btn = 4'd0;
    logic       v = 1'b0;
    logic [1:0] cmd = 2'd0;
    logic       rdy, busy, last;
    logic [3:0] pul;
    int         n_cmp = 0, n_bad = 0;
    typedef struct {
        logic [3:0] btn;
        logic       v;
        logic [1:0] cmd;
        int         n;
        logic       rdy;
        logic [3:0] pul;
        logic       busy;
        logic       last;
    } vec_t;
    vec_t tbl[$];
    int   m_c, m_edge, m_free, m_issue;
    logic [3:0] m_prev;
    logic m_pend, m_last, m_isrc;
    logic [1:0] m_pcode, m_icode;
    always #5 clk = ~clk;
    metronome_cmd_arbiter #(
        .GAP_CYCLES   (GAP),
        .HOLD_CYCLES  (HOLD),
        .REPEAT_CYCLES(REP)
    ) dut (
        .i_clk           (clk),
        .i_reset         (rst),
        .i_btn_plus_1    (btn[0]),
        .i_btn_plus_5    (btn[1]),
        .i_btn_minus_1   (btn[2]),
        .i_btn_minus_5   (btn[3]),
        .i_uart_cmd_valid(v),
        .i_uart_cmd      (cmd),
        .o_uart_cmd_ready(rdy),
        .o_plus_1        (pul[0]),
        .o_plus_5        (pul[1]),
        .o_minus_1       (pul[2]),
        .o_minus_5       (pul[3]),
        .o_busy          (busy),
        .o_last_src      (last)
    );
    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask
    task automatic chk_all(input string nm, input int r, input int p, input int b, input int l);
        chk({nm, " ready"}, int'(rdy), r);
        chk({nm, " pulses"}, int'(pul), p);
        chk({nm, " busy"}, int'(busy), b);
        chk({nm, " last_src"}, int'(last), l);
    endtask
    task automatic do_reset();
        btn = 4'd0;
        v   = 1'b0;
        cmd = 2'd0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_all("reset", 0, 0, 0, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask
    function automatic logic [1:0] idx(input logic [3:0] b);
        for (int i = 0; i < 4; i++) if (b[i]) return 2'(i);
        return 2'd0;
    endfunction
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
    initial begin
        // {btn, valid, cmd, cycles, ready, pulses{m5,m1,p5,p1}, busy, last_src}
        tbl.push_back('{4'b0000, 1'b0, 2'd0,  3, 1'b0, 4'b0000, 1'b0, 1'b0});
        tbl.push_back('{4'b0000, 1'b1, 2'd1,  1, 1'b1, 4'b0000, 1'b0, 1'b0});
        tbl.push_back('{4'b0000, 1'b0, 2'd0,  1, 1'b0, 4'b0010, 1'b1, 1'b0});
        tbl.push_back('{4'b0000, 1'b0, 2'd0, 16, 1'b0, 4'b0000, 1'b1, 1'b1});
        tbl.push_back('{4'b0000, 1'b0, 2'd0,  2, 1'b0, 4'b0000, 1'b0, 1'b1});
        tbl.push_back('{4'b0100, 1'b0, 2'd0,  2, 1'b0, 4'b0000, 1'b0, 1'b1});
        tbl.push_back('{4'b0100, 1'b0, 2'd0,  1, 1'b0, 4'b0100, 1'b1, 1'b1});
        tbl.push_back('{4'b0000, 1'b0, 2'd0, 16, 1'b0, 4'b0000, 1'b1, 1'b0});
        tbl.push_back('{4'b0000, 1'b0, 2'd0,  2, 1'b0, 4'b0000, 1'b0, 1'b0});
        tbl.push_back('{4'b0001, 1'b0, 2'd0,  1, 1'b0, 4'b0000, 1'b0, 1'b0});
        tbl.push_back('{4'b0001, 1'b1, 2'd3,  1, 1'b1, 4'b0000, 1'b0, 1'b0});
        tbl.push_back('{4'b0000, 1'b0, 2'd0,  1, 1'b0, 4'b1000, 1'b1, 1'b0});
        tbl.push_back('{4'b0000, 1'b0, 2'd0, 16, 1'b0, 4'b0000, 1'b1, 1'b1});
        tbl.push_back('{4'b0000, 1'b0, 2'd0,  1, 1'b0, 4'b0000, 1'b0, 1'b1});
        tbl.push_back('{4'b0000, 1'b0, 2'd0,  1, 1'b0, 4'b0001, 1'b1, 1'b1});
        tbl.push_back('{4'b0000, 1'b0, 2'd0, 16, 1'b0, 4'b0000, 1'b1, 1'b0});
        tbl.push_back('{4'b0000, 1'b0, 2'd0,  2, 1'b0, 4'b0000, 1'b0, 1'b0});
        tbl.push_back('{4'b1001, 1'b0, 2'd0,  3, 1'b0, 4'b0000, 1'b0, 1'b0});
        tbl.push_back('{4'b1001, 1'b1, 2'd0,  1, 1'b1, 4'b0000, 1'b0, 1'b0});
        tbl.push_back('{4'b1001, 1'b0, 2'd0,  1, 1'b0, 4'b0001, 1'b1, 1'b0});
        tbl.push_back('{4'b0000, 1'b0, 2'd0, 16, 1'b0, 4'b0000, 1'b1, 1'b1});
        tbl.push_back('{4'b0000, 1'b0, 2'd0,  2, 1'b0, 4'b0000, 1'b0, 1'b1});
        do_reset();
        foreach (tbl[i]) begin
            for (int k = 0; k < tbl[i].n; k++) begin
                btn = tbl[i].btn;
                v   = tbl[i].v;
                cmd = tbl[i].cmd;
                @(negedge clk);
                chk_all($sformatf("vec%0d.%0d", i, k), int'(tbl[i].rdy), int'(tbl[i].pul),
                        int'(tbl[i].busy), int'(tbl[i].last));
                @(posedge clk);
                #1;
            end
        end
        // auto-repeat: hold +1 for 165 cycles, then release
        begin
            int offs[$];
            int others;
            int exp_off[5];
            exp_off = '{2, 2 + HOLD, 2 + HOLD + REP, 2 + HOLD + 2 * REP, 2 + HOLD + 3 * REP};
            others = 0;
            do_reset();
            for (int c = 0; c < 205; c++) begin
                btn = c < 165 ? 4'b0001 : 4'b0000;
                @(negedge clk);
                if (pul[0]) offs.push_back(c);
                if (pul[3:1] != 3'd0) others++;
                @(posedge clk);
                #1;
            end
            chk("repeat pulse count", offs.size(), 5);
            chk("repeat other pulses", others, 0);
            for (int i = 0; i < 5; i++) chk($sformatf("repeat pulse %0d cycle", i),
                                             i < offs.size() ? offs[i] : -1, exp_off[i]);
        end
        // async reset in GAP with a button pending
        begin
            int stale;
            stale = 0;
            v   = 1'b1;
            cmd = 2'd3;
            @(negedge clk);
            chk("rstgap ready", int'(rdy), 1);
            @(posedge clk);
            #1;
            v   = 1'b0;
            btn = 4'b0010;
            @(negedge clk);
            chk("rstgap minus_5 pulse", int'(pul), 8);
            @(posedge clk);
            #1;
            @(posedge clk);
            #3;
            rst = 1'b1;
            btn = 4'b0000;
            #1;
            chk_all("rstgap immediate", 0, 0, 0, 0);
            @(posedge clk);
            #3;
            rst = 1'b0;
            @(posedge clk);
            #1;
            v   = 1'b1;
            cmd = 2'd0;
            @(negedge clk);
            chk_all("rstgap first idle", 1, 0, 0, 0);
            @(posedge clk);
            #1;
            v = 1'b0;
            @(negedge clk);
            chk("rstgap new pulse", int'(pul), 1);
            for (int c = 0; c < 40; c++) begin
                @(posedge clk);
                #1;
                @(negedge clk);
                if (pul != 4'd0) stale++;
            end
            chk("rstgap stale pulses", stale, 0);
            @(posedge clk);
            #1;
        end
        // randomized run against a timeline model
        do_reset();
        m_c = 0; m_edge = -1; m_free = 0; m_issue = -1;
        m_prev = 4'd0; m_pend = 1'b0; m_last = 1'b0; m_isrc = 1'b0;
        m_pcode = 2'd0; m_icode = 2'd0;
        for (int c = 0; c < 3000; c++) begin
            logic idle, gu, gb, single, rise, fire, acc;
            int el;
            if ($urandom_range(149) == 0) begin
                case ($urandom_range(3))
                    0: btn = 4'd0;
                    1, 2: btn = 4'd1 << $urandom_range(3);
                    default: btn = 4'($urandom);
                endcase
            end
            if (!v && $urandom_range(7) == 0) begin
                v   = 1'b1;
                cmd = 2'($urandom);
            end
            @(negedge clk);
            idle = m_c >= m_free;
            gu   = idle && v && (!m_pend || !m_last);
            gb   = idle && m_pend && !gu;
            chk_all("rand", int'(gu), m_c == m_issue ? 1 << m_icode : 0, int'(!idle), int'(m_last));
            acc = gu;
            if (m_c == m_issue) m_last = m_isrc;
            if (gu || gb) begin
                m_issue = m_c + 1;
                m_free  = m_c + 2 + GAP;
                m_icode = gu ? cmd : m_pcode;
                m_isrc  = gu;
            end
            single = $countones(btn) == 1;
            rise   = single && btn != m_prev;
            el     = m_c - m_edge;
            fire   = single && btn == m_prev && m_edge >= 0 &&
                     (el == HOLD || (el > HOLD && (el - HOLD) % REP == 0));
            if (!single) m_edge = -1;
            else if (rise) m_edge = m_c;
            if (gb) m_pend = 1'b0;
            else if ((rise || fire) && !m_pend) begin
                m_pend  = 1'b1;
                m_pcode = idx(btn);
            end
            m_prev = btn;
            m_c++;
            @(posedge clk);
            #1;
            if (acc) v = 1'b0;
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/metronome_cmd_arbiter.md
Name: metronome_cmd_arbiter

Overview:
Sequences tempo-change commands into the metronome core. It arbitrates between two requesters: the debounced local buttons, with auto-repeat on hold, and a UART command decoder using a valid/ready handshake. Each granted command becomes exactly one single-cycle pulse on one of the four metronome adjust inputs. A guaranteed idle gap follows every pulse so the metronome can recompute its bpm counter. The block sits between btn_debouncer/UART RX decoding and metronome, on the PLL clock domain.

Parameters:
GAP_CYCLES, 16, idle cycles enforced after every issued pulse (>=1)
HOLD_CYCLES, 25_000_000, cycles a single button must stay held before the first auto-repeat
REPEAT_CYCLES, 5_000_000, cycles between subsequent auto-repeats while held

Ports:
i_clk  in  1  PLL clock
i_reset  in  1  asynchronous active-high reset
i_btn_plus_1  in  1  debounced level, +1 bpm button
i_btn_plus_5  in  1  debounced level, +5 bpm button
i_btn_minus_1  in  1  debounced level, -1 bpm button
i_btn_minus_5  in  1  debounced level, -5 bpm button
i_uart_cmd_valid  in  1  UART command valid
i_uart_cmd  in  2  UART command code (00 +1, 01 +5, 10 -1, 11 -5)
o_uart_cmd_ready  out  1  UART command accepted this cycle (combinational)
o_plus_1  out  1  one-cycle pulse to metronome +1
o_plus_5  out  1  one-cycle pulse to metronome +5
o_minus_1  out  1  one-cycle pulse to metronome -1
o_minus_5  out  1  one-cycle pulse to metronome -5
o_busy  out  1  high in ISSUE and GAP states
o_last_src  out  1  source of the last grant (0 button, 1 UART)

Behaviour:
- Reset (async): state IDLE; all pulse outputs, o_busy and o_last_src = 0; button pending slot cleared; hold/repeat counters cleared; previous-level regs cleared. Commands in flight are discarded.
- Button front end: register the previous levels. A "single press" means exactly one of the four levels is high. Two or more levels high means conflict: generate no request and clear the hold counter.
- A rising edge into a single-press state at cycle T sets btn_pending with that code at the T+1 edge.
- While the same single press stays held, the hold counter runs. At HOLD_CYCLES after the edge it sets pending, then again every REPEAT_CYCLES.
- If pending is already set when a new edge or repeat fires, the new request is dropped. There is no accumulation.
- Release or conflict clears the hold counter. An already-pending request is kept.
- FSM IDLE: candidates are btn_pending and i_uart_cmd_valid.
  - Single candidate: grant it.
  - Both: round-robin, granting the source not equal to o_last_src.
  - o_uart_cmd_ready = 1 only in IDLE when UART is granted. A grant to buttons clears btn_pending.
  - Next state ISSUE; the granted code is latched into a register.
- FSM ISSUE: the decoded pulse output is high for exactly this one cycle; o_last_src is updated. Next state GAP, with the gap counter loaded to GAP_CYCLES-1.
- FSM GAP: decrement the counter. At 0, go to IDLE. No grants and no ready in ISSUE or GAP; button edges are still captured into pending.
- Latency, idle block: UART handshake at cycle T gives a pulse during T+1. Button edge at T gives a pulse during T+2.
- Back-to-back: under a continuous backlog, pulse rising edges are exactly GAP_CYCLES+2 cycles apart. No more than one pulse output is ever high at once.
- Counter widths: $clog2 of the respective parameter +1; counters saturate and never wrap.

Decomposition:
- Package metronome_pkg holds:
  - command code localparams CMD_PLUS_1/PLUS_5/MINUS_1/MINUS_5;
  - FSM state encoding ST_IDLE/ST_ISSUE/ST_GAP;
  - source encoding SRC_BTN/SRC_UART.
- Sub-module btn_repeat_gen holds the button edge detect, conflict check, hold/repeat counters and pending slot. Its interface is the four button levels in, plus pending/code out and a clear-pending in.

Test Plan:
- Idle; UART valid with cmd=01 at cycle 10 -> ready=1 at cycle 10, o_plus_5 high only at cycle 11, o_busy high cycles 11..27 (GAP_CYCLES=16).
- Press i_btn_minus_1 at cycle 5 and hold 3 cycles -> o_minus_1 single pulse at cycle 7; no other pulses.
- Button pending and UART valid together, o_last_src=0 -> UART granted first; button pulse follows 18 cycles later; then o_last_src=0.
- Override HOLD=100, REPEAT=20; hold i_btn_plus_1 for 165 cycles -> pulses at the edge+2, ~edge+101, ~edge+121, ~edge+141, ~edge+161 (4 repeats); none after release.
- i_btn_plus_1 and i_btn_minus_5 rising together -> no pulse, o_uart_cmd_ready unaffected.
- Assert i_reset during GAP, right after an o_minus_5 pulse with a button pending -> all outputs 0 immediately; after release, no stale pulse; a new UART cmd is accepted on the first IDLE cycle.
